// File: rtl/serial_in_pkg.sv
// serial_in_pkg: shared constants for the serial input loader.
//   HDR_W      - frame header width (selects one of the four operand registers)
//   NUM_REGS   - number of operand registers addressed by the header
//   IDX_*      - register index of each operand as carried in the header
//   state_t    - loader FSM state encoding
package serial_in_pkg;

    localparam int HDR_W    = 2;
    localparam int NUM_REGS = 4;

    localparam int IDX_MSG    = 0;
    localparam int IDX_ENCR   = 1;
    localparam int IDX_GENMAT = 2;
    localparam int IDX_MSGIN  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        DATA     = 3'd2,
        PAR      = 3'd3,
        COMMIT   = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

endpackage

// File: rtl/serial_deser_shift.sv
// serial_deser_shift: payload deserializer for serial_in_loader.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear of shadow, bit counter and parity
//   shift_en    - shift bit_in into the shadow register this cycle
//   bit_in      - serial data bit, MSB first
//   shadow      - Y-bit shift register contents
//   last_bit    - high when the current shift delivers the Y-th payload bit
//   parity      - running XOR of all payload bits shifted in since clr
module serial_deser_shift #(
    parameter int Y = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [Y-1:0] shadow,
    output logic         last_bit,
    output logic         parity
);

    localparam int CW = $clog2(Y);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            shadow <= {shadow[Y-2:0], bit_in};
            cnt    <= cnt + 1'b1;
            parity <= parity ^ bit_in;
        end
    end

    // Combinational so the loader can commit on the very edge that samples
    // the last bit.
    assign last_bit = shift_en && (cnt == CW'(Y - 1));

endmodule

// File: rtl/serial_in_loader.sv
// serial_in_loader: deserializes framed serial input into the four operand
// registers of the Kyber top and issues its start pulse.
//
// Frame: while frame_en is high, HDR_W header bits (register index) then Y
// payload bits, MSB first, each taken on a cycle with ser_valid=1. With
// SERIAL_IN_PARITY_EN defined, one trailing even-parity bit over header and
// payload follows and must match for the frame to commit.
//
// Ports:
//   CLK, RST_N       - clock, asynchronous active-low reset
//   ser_in/ser_valid - serial bit and its qualifier
//   frame_en         - frame envelope
//   go               - start request (honoured when all four loaded, IDLE)
//   clear            - synchronous clear of everything
//   message, encr_message, genmat_message, msg_in - operand registers 0..3
//   loaded           - per-register loaded flags
//   start            - one-cycle start pulse
//   busy             - frame in progress (state != IDLE)
//   frame_done       - one-cycle pulse, visible together with the new value
//   frame_err        - one-cycle pulse on abort or parity failure
module serial_in_loader
    import serial_in_pkg::*;
#(
    parameter int Y = 128
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         frame_en,
    input  logic         go,
    input  logic         clear,
    output logic [Y-1:0] message,
    output logic [Y-1:0] encr_message,
    output logic [Y-1:0] genmat_message,
    output logic [Y-1:0] msg_in,
    output logic [3:0]   loaded,
    output logic         start,
    output logic         busy,
    output logic         frame_done,
    output logic         frame_err
);

    localparam int HCW = $clog2(HDR_W) + 1;

    state_t                        state;
    logic [NUM_REGS-1:0][Y-1:0]    regs;
    logic [HDR_W-1:0]              idx;
    logic [HCW-1:0]                hdr_cnt;
    logic                          go_lock;

    logic [Y-1:0] shadow;
    logic         last_bit;
    logic         parity;
    logic         shift_en;
    logic         shr_clr;
    logic         start_ok;

    assign shift_en = (state == DATA) && ser_valid && frame_en;
    // The shifter idles cleared, so every frame starts from a zero count.
    assign shr_clr  = clear || (state == IDLE);
    // go_lock keeps a held go from re-firing until it has dropped.
    assign start_ok = go && !go_lock && (loaded == 4'hF) && (state == IDLE);

    serial_deser_shift #(.Y(Y)) u_shift (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (shr_clr),
        .shift_en (shift_en),
        .bit_in   (ser_in),
        .shadow   (shadow),
        .last_bit (last_bit),
        .parity   (parity)
    );

`ifdef SERIAL_IN_PARITY_EN
    // Even parity over header and payload bits.
    logic par_exp;
    assign par_exp = parity ^ (^idx);
`else
    // Word including the bit being sampled, so the register is written on
    // the same edge that takes the last payload bit.
    logic [Y-1:0] data_word;
    logic [1:0]   unused_bits;
    assign data_word   = {shadow[Y-2:0], ser_in};
    assign unused_bits = {shadow[Y-1], parity};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            regs       <= '0;
            idx        <= '0;
            hdr_cnt    <= '0;
            loaded     <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            go_lock    <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            regs       <= '0;
            idx        <= '0;
            hdr_cnt    <= '0;
            loaded     <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            go_lock    <= 1'b0;
        end else begin
            start      <= start_ok;
            go_lock    <= go && (go_lock || start_ok);
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A valid bit in this cycle belongs to no field.
                    if (frame_en) begin
                        state   <= HDR;
                        hdr_cnt <= '0;
                        idx     <= '0;
                    end
                end
                HDR: begin
                    if (!frame_en) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (ser_valid) begin
                        idx     <= HDR_W'({idx, ser_in});
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_cnt == HCW'(HDR_W - 1))
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (!frame_en) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (last_bit) begin
`ifdef SERIAL_IN_PARITY_EN
                        state <= PAR;
`else
                        regs[idx]   <= data_word;
                        loaded[idx] <= 1'b1;
                        frame_done  <= 1'b1;
                        state       <= COMMIT;
`endif
                    end
                end
                PAR: begin
`ifdef SERIAL_IN_PARITY_EN
                    if (!frame_en) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (ser_valid) begin
                        if (ser_in == par_exp) begin
                            regs[idx]   <= shadow;
                            loaded[idx] <= 1'b1;
                            frame_done  <= 1'b1;
                            state       <= COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_LOW;
                        end
                    end
`else
                    state <= IDLE;
`endif
                end
                // The write already landed on entry; this is the cycle the
                // new value and frame_done are visible.
                COMMIT:   state <= WAIT_LOW;
                WAIT_LOW: if (!frame_en) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign message        = regs[IDX_MSG];
    assign encr_message   = regs[IDX_ENCR];
    assign genmat_message = regs[IDX_GENMAT];
    assign msg_in         = regs[IDX_MSGIN];
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_serial_in_loader.sv
module tb_serial_in_loader;

    localparam int Y  = 128;
    localparam int HW = 2;

    logic CLK = 1'b0, RST_N = 1'b0;
    logic ser_in = 1'b0, ser_valid = 1'b0, frame_en = 1'b0, go = 1'b0, clear = 1'b0;
    logic [Y-1:0] message, encr_message, genmat_message, msg_in;
    logic [3:0]   loaded;
    logic         start, busy, frame_done, frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model: what each register should hold and which were loaded.
    logic [Y-1:0] mreg [4];
    logic [3:0]   mloaded;

`ifdef SERIAL_IN_PARITY_EN
    bit flip_par = 1'b0;
`endif

    always #5 CLK = ~CLK;

    serial_in_loader #(.Y(Y)) dut (
        .CLK(CLK), .RST_N(RST_N), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_en(frame_en), .go(go), .clear(clear),
        .message(message), .encr_message(encr_message),
        .genmat_message(genmat_message), .msg_in(msg_in),
        .loaded(loaded), .start(start), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    function automatic logic [Y-1:0] dut_reg(input int i);
        case (i)
            0:       return message;
            1:       return encr_message;
            2:       return genmat_message;
            default: return msg_in;
        endcase
    endfunction

    function automatic logic [Y-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        mloaded = 4'h0;
    endtask

    // One valid bit, preceded by 0..max_gap idle cycles carrying junk.
    task automatic drive_bit(input logic b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge CLK); ser_valid = 1'b0; ser_in = 1'($urandom_range(1, 0));
        end
        @(negedge CLK); ser_valid = 1'b1; ser_in = b;
    endtask

    // Drives a frame; returns right after the last bit has been presented.
    // abort_at >= 0 drops frame_en after that many payload bits.
    task automatic send_frame(input logic [1:0] idx, input logic [Y-1:0] pay,
                              input int max_gap, input int abort_at);
        logic [HW+Y-1:0] bits;
        bits = {idx, pay};
        // Valid bit during the IDLE cycle must not be consumed.
        @(negedge CLK); frame_en = 1'b1; ser_valid = 1'b1; ser_in = 1'($urandom_range(1, 0));
        for (int i = HW + Y - 1; i >= 0; i--) begin
            if (abort_at >= 0 && (HW + Y - 1 - i) == HW + abort_at) begin
                @(negedge CLK); frame_en = 1'b0; ser_valid = 1'b0;
                return;
            end
            drive_bit(bits[i], max_gap);
        end
`ifdef SERIAL_IN_PARITY_EN
        drive_bit((^bits) ^ flip_par, max_gap);
`endif
    endtask

    task automatic end_frame();
        ser_valid = 1'b0; frame_en = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    // Full good frame with commit-latency checks, model updated.
    task automatic load_frame(input int k, input logic [Y-1:0] pay, input int max_gap);
        send_frame(2'(k), pay, max_gap, -1);
        @(negedge CLK);
        mreg[k] = pay; mloaded[k] = 1'b1;
        checks++;
        if (frame_done !== 1'b1 || dut_reg(k) !== pay) begin
            errors++;
            $display("FAIL commit_latency idx=%0d: frame_done=%b reg=%h expected frame_done=1 reg=%h",
                     k, frame_done, dut_reg(k), pay);
        end
        end_frame();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_clear();
        @(negedge CLK);
        checks++;
        if ({message, encr_message, genmat_message, msg_in} !== '0) begin
            errors++; $display("FAIL reset_regs: got nonzero registers, expected 0");
        end
        checks++;
        if ({loaded, start, busy, frame_done, frame_err} !== 8'h0) begin
            errors++;
            $display("FAIL reset_flags: loaded=%h start=%b busy=%b done=%b err=%b expected all 0",
                     loaded, start, busy, frame_done, frame_err);
        end
    endtask

    task automatic test_load_all();
        logic [Y-1:0] pay [4];
        logic [3:0]   exp_ld [4];
        pay[0] = 128'h58256fdfef6a5f8fa09c171607a93bdd;
        pay[1] = 128'h1;
        pay[2] = 128'hea97e8a6e6dd65e2873f1cc1d44098d8;
        pay[3] = 128'h0f0e0d0c0b0a09080706050403020100;
        exp_ld[0] = 4'h1; exp_ld[1] = 4'h3; exp_ld[2] = 4'h7; exp_ld[3] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            send_frame(2'(k), pay[k], 0, -1);
            @(negedge CLK);
            mreg[k] = pay[k]; mloaded[k] = 1'b1;
            checks++;
            if (frame_done !== 1'b1) begin
                errors++; $display("FAIL load_done idx=%0d: frame_done=%b expected 1", k, frame_done);
            end
            checks++;
            if (loaded !== exp_ld[k]) begin
                errors++; $display("FAIL load_loaded idx=%0d: got %h expected %h", k, loaded, exp_ld[k]);
            end
            ser_valid = 1'b0; frame_en = 1'b0;
            @(negedge CLK);
            checks++;
            if (frame_done !== 1'b0) begin
                errors++; $display("FAIL load_done_pulse idx=%0d: frame_done=%b expected 0", k, frame_done);
            end
            @(negedge CLK);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_reg(k) !== mreg[k]) begin
                errors++; $display("FAIL load_reg idx=%0d: got %h expected %h", k, dut_reg(k), mreg[k]);
            end
        end
    endtask

    task automatic test_start();
        int nst, first;
        @(negedge CLK); clear = 1'b1;
        @(negedge CLK); clear = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) load_frame(k, rand_word(), 0);
        go = 1'b1;
        nst = 0;
        repeat (4) begin @(negedge CLK); if (start) nst++; end
        go = 1'b0;
        checks++;
        if (nst != 0 || loaded !== 4'h7) begin
            errors++; $display("FAIL start_not_loaded: starts=%0d loaded=%h expected 0 starts loaded=7", nst, loaded);
        end
        @(negedge CLK);
        load_frame(3, rand_word(), 0);
        go = 1'b1;
        nst = 0; first = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (start) begin nst++; if (first < 0) first = c; end
            if (c == 4) go = 1'b0;
        end
        checks++;
        if (nst != 1 || first != 0) begin
            errors++; $display("FAIL start_held_go: pulses=%0d first_cycle=%0d expected 1 pulse at cycle 0", nst, first);
        end
        checks++;
        if (loaded !== 4'hF) begin
            errors++; $display("FAIL start_loaded_kept: got %h expected f", loaded);
        end
        @(negedge CLK); go = 1'b1;
        @(negedge CLK);
        checks++;
        if (start !== 1'b1) begin
            errors++; $display("FAIL start_rearm: start=%b expected 1", start);
        end
        go = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_go_clear();
        @(negedge CLK); go = 1'b1; clear = 1'b1;
        @(negedge CLK);
        checks++;
        if (start !== 1'b0 || loaded !== 4'h0) begin
            errors++; $display("FAIL clear_over_go: start=%b loaded=%h expected start=0 loaded=0", start, loaded);
        end
        go = 1'b0; clear = 1'b0;
        model_clear();
        for (int k = 0; k < 4; k++) load_frame(k, rand_word(), 0);
        // go and frame_en rising together: start fires and the frame begins.
        @(negedge CLK); go = 1'b1; frame_en = 1'b1; ser_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL go_with_frame: start=%b busy=%b expected 1 1", start, busy);
        end
        go = 1'b0; frame_en = 1'b0;
        @(negedge CLK);
        checks++;
        if (frame_err !== 1'b1 || loaded !== mloaded) begin
            errors++; $display("FAIL hdr_abort: frame_err=%b loaded=%h expected 1 %h", frame_err, loaded, mloaded);
        end
        @(negedge CLK);
    endtask

    task automatic test_abort();
        send_frame(2'd1, rand_word(), 0, 60);
        @(negedge CLK);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL abort_err: frame_err=%b expected 1", frame_err);
        end
        checks++;
        if (encr_message !== mreg[1] || loaded !== mloaded) begin
            errors++; $display("FAIL abort_unchanged: reg=%h loaded=%h expected %h %h",
                               encr_message, loaded, mreg[1], mloaded);
        end
        @(negedge CLK);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_pulse: frame_err=%b busy=%b expected 0 0", frame_err, busy);
        end
        load_frame(1, rand_word(), 0);
    endtask

    task automatic test_gaps();
        for (int n = 0; n < 4; n++)
            load_frame(int'($urandom_range(3, 0)), rand_word(), 7);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_reg(k) !== mreg[k]) begin
                errors++; $display("FAIL gaps_reg idx=%0d: got %h expected %h", k, dut_reg(k), mreg[k]);
            end
        end
    endtask

`ifdef SERIAL_IN_PARITY_EN
    task automatic test_parity();
        load_frame(2, rand_word(), 2);
        flip_par = 1'b1;
        send_frame(2'd0, rand_word(), 0, -1);
        @(negedge CLK);
        checks++;
        if (frame_err !== 1'b1 || frame_done !== 1'b0) begin
            errors++; $display("FAIL parity_bad: err=%b done=%b expected 1 0", frame_err, frame_done);
        end
        checks++;
        if (message !== mreg[0] || loaded !== mloaded) begin
            errors++; $display("FAIL parity_unchanged: reg=%h loaded=%h expected %h %h",
                               message, loaded, mreg[0], mloaded);
        end
        flip_par = 1'b0;
        end_frame();
    endtask
`endif

    task automatic test_clear_mid();
        logic [HW+Y-1:0] bits;
        int nerr;
        bits = {2'd3, rand_word()};
        @(negedge CLK); frame_en = 1'b1; ser_valid = 1'b0;
        for (int i = HW + Y - 1; i >= HW + Y - 32; i--) drive_bit(bits[i], 0);
        @(negedge CLK); clear = 1'b1; frame_en = 1'b0; ser_valid = 1'b0;
        @(negedge CLK); clear = 1'b0;
        model_clear();
        checks++;
        if ({message, encr_message, genmat_message, msg_in} !== '0 || loaded !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_mid: loaded=%h busy=%b expected all registers 0, loaded 0, busy 0", loaded, busy);
        end
        nerr = (frame_err === 1'b1) ? 1 : 0;
        repeat (3) begin @(negedge CLK); if (frame_err === 1'b1) nerr++; end
        checks++;
        if (nerr != 0) begin
            errors++; $display("FAIL clear_no_err: frame_err pulses=%0d expected 0", nerr);
        end
    endtask

    task automatic test_async_reset();
        logic [HW+Y-1:0] bits;
        load_frame(0, rand_word(), 0);
        bits = {2'd1, rand_word()};
        @(negedge CLK); frame_en = 1'b1; ser_valid = 1'b0;
        for (int i = HW + Y - 1; i >= HW + Y - 22; i--) drive_bit(bits[i], 0);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({message, encr_message, genmat_message, msg_in} !== '0 ||
            {loaded, start, busy, frame_done, frame_err} !== 8'h0) begin
            errors++; $display("FAIL async_reset: loaded=%h busy=%b msg=%h expected all 0", loaded, busy, message);
        end
        @(negedge CLK); frame_en = 1'b0; ser_valid = 1'b0; RST_N = 1'b1;
        model_clear();
        @(negedge CLK);
        load_frame(2, rand_word(), 1);
        checks++;
        if (loaded !== 4'h4 || genmat_message !== mreg[2]) begin
            errors++; $display("FAIL post_reset_load: loaded=%h reg=%h expected 4 %h", loaded, genmat_message, mreg[2]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        test_reset();
        test_load_all();
        test_start();
        test_go_clear();
        test_abort();
        test_gaps();
`ifdef SERIAL_IN_PARITY_EN
        test_parity();
`endif
        test_clear_mid();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_in_loader.md
Name: serial_in_loader

Overview:
Upstream serial front end for the Kyber top level. It deserializes framed serial input into the four Y-bit operand registers consumed by the top: message, encr_message, genmat_message and msg_in. Once all four registers are loaded, a host go request produces the single-cycle start pulse. It is the input-side counterpart of the serial_out stage.

Parameters:
Y, 128, data width of each operand register and each frame payload (bits)
HDR_W, 2, frame header width; selects the target register index 0..3

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
ser_in  input  1  serial data bit, MSB first
ser_valid  input  1  ser_in is sampled on this cycle
frame_en  input  1  frame envelope; high for the whole frame
go  input  1  request to start the top-level operation
clear  input  1  synchronous clear of all registers and flags
message  output  Y  operand register, index 0
encr_message  output  Y  operand register, index 1
genmat_message  output  Y  operand register, index 2
msg_in  output  Y  operand register, index 3
loaded  output  4  per-register loaded flags; bit i = index i
start  output  1  one-cycle start pulse to the top FSM
busy  output  1  high while a frame is in progress (state not IDLE)
frame_done  output  1  one-cycle pulse on a successful commit
frame_err  output  1  one-cycle pulse on abort or check failure

Behaviour:
- Reset (RST_N low, asynchronous) and clear (synchronous, highest priority):
  - All outputs, the shadow register and the counters go to 0.
  - State goes to IDLE.
  - clear during a frame discards the frame and does not pulse frame_err.
- ser_in is sampled only when ser_valid=1 and frame_en=1. Cycles with ser_valid=0 hold all state, so gaps of any length are allowed.
- States:
  - IDLE: frame_en=1 -> HDR; the header counter and bit counter are zeroed. A bit that is valid in this same cycle is not consumed.
  - HDR: shifts in HDR_W bits, MSB first, into idx. After the HDR_W-th bit -> DATA.
  - DATA: shadow <= {shadow[Y-2:0], ser_in} per valid bit. After the Y-th bit -> COMMIT, or -> PAR when the optional feature is compiled in.
  - COMMIT (one cycle): target[idx] <= shadow, loaded[idx] <= 1, frame_done=1 -> WAIT_LOW.
  - WAIT_LOW: extra valid bits are ignored. frame_en=0 -> IDLE.
- Abort: frame_en falling while in HDR or DATA (or PAR) -> IDLE.
  - frame_err pulses on the next cycle.
  - The target register and loaded are unchanged.
- Register update rule: a register changes only in COMMIT. Reloading an index overwrites it; loaded stays 1.
- Start:
  - Condition: go=1 and loaded==4'hF and state==IDLE.
  - Response: start=1 in the following cycle, for exactly one cycle.
  - loaded is unchanged by start.
  - go is ignored if the condition fails (no error).
  - go held high produces a single pulse; go must fall for at least one cycle before the next start.
- Simultaneous events:
  - go and frame_en rising in the same IDLE cycle: start takes effect and the frame also begins.
  - clear overrides go.
- busy = (state != IDLE).
- Latency: the last data bit is sampled in cycle t; the register is updated and frame_done asserts in cycle t+1.

Optional Feature:
- Macro: SERIAL_IN_PARITY_EN.
- Defined:
  - After DATA, a PAR state samples one extra valid bit, which must equal the even parity (XOR) of the HDR_W+Y bits received.
  - On match -> COMMIT.
  - On mismatch -> frame_err pulse and WAIT_LOW, with no register update.
- Not defined: no PAR state; DATA -> COMMIT directly.

Decomposition:
- Package serial_in_pkg holds:
  - index constants IDX_MSG=0, IDX_ENCR=1, IDX_GENMAT=2, IDX_MSGIN=3;
  - HDR_W;
  - state encoding IDLE, HDR, DATA, PAR, COMMIT, WAIT_LOW.
- One sub-module: serial_deser_shift.
  - Contents: Y-bit shift register, bit counter, running parity.
  - Controls: shift enable and clear.
  - Outputs: last_bit flag and parity.
- The FSM, the four registers and the start logic stay in serial_in_loader.

Test Plan:
- Load four frames with headers 0..3 and payloads 128'h58256fdfef6a5f8fa09c171607a93bdd, 128'h1, 128'hea97e8a6e6dd65e2873f1cc1d44098d8, 128'h0f0e...0100 -> each register exact; loaded steps 1,3,7,F; four frame_done pulses.
- go with loaded=4'h7 -> no start. Load index 3, then go held for 5 cycles -> exactly one start pulse, one cycle after go is sampled.
- Frame index 1 with frame_en dropped after 60 data bits -> frame_err pulse; encr_message and loaded[1] unchanged; the next full frame loads correctly.
- Random ser_valid gaps (0-7 idle cycles between bits) -> same register values as the gapless case.
- RST_N asserted mid-DATA with no clock edge -> outputs 0 immediately. clear mid-frame -> all 0, no frame_err.
- With SERIAL_IN_PARITY_EN: correct parity bit -> commit. Flipped parity bit -> frame_err; register and loaded unchanged.
